// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter: round-robin APB master sharing one slave among N_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_rr_master_arbiter #(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = 30,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        pclk,
    input  logic                        prst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [N_REQ*STRB_WIDTH-1:0] req_strb,
    input  logic [N_REQ*3-1:0]          req_prot,
    output logic [N_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic [N_REQ-1:0]            grant,
    output logic                        pwakeup,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic [DATA_WIDTH-1:0]       pwdata,
    output logic [STRB_WIDTH-1:0]       pstrb,
    output logic [2:0]                  pprot,
    input  logic                        pready,
    input  logic [DATA_WIDTH-1:0]       prdata,
    input  logic                        pslverr
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("apb_rr_master_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        rr_ptr, rr_ptr_n, idx, idx_n, win;
    logic [N_REQ-1:0]        elig, grant_n, req_done_n;
    logic                    found, fin;
    logic                    psel_n, penable_n, pwrite_n, pwakeup_n, rsp_err_n;
    logic [ADDR_WIDTH-1:0]   paddr_n;
    logic [DATA_WIDTH-1:0]   pwdata_n, rsp_rdata_n;
    logic [STRB_WIDTH-1:0]   pstrb_n;
    logic [2:0]              pprot_n;
`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        tcnt, tcnt_n;
`endif

    // The completing requester is masked so it cannot be regranted in its req_done cycle.
    always_comb begin
        elig  = req_valid & ~req_done;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        idx_n       = idx;
        grant_n     = grant;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        pstrb_n     = pstrb;
        pprot_n     = pprot;
        pwakeup_n   = pwakeup;
        req_done_n  = '0;
        rsp_rdata_n = '0;
        rsp_err_n   = 1'b0;
        fin         = 1'b0;
`ifdef APB_TIMEOUT_EN
        tcnt_n      = tcnt;
`endif
        case (state)
            IDLE: begin
                pwakeup_n = found;
                if (found) begin
                    state_n   = SETUP;
                    idx_n     = win;
                    grant_n   = N_REQ'(1) << win;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    pwrite_n  = req_write[win];
                    paddr_n   = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_n  = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    pstrb_n   = req_write[win] ? req_strb[int'(win)*STRB_WIDTH +: STRB_WIDTH] : '0;
                    pprot_n   = req_prot[int'(win)*3 +: 3];
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
`ifdef APB_TIMEOUT_EN
                tcnt_n    = '0;
`endif
            end
            ACCESS: begin
`ifdef APB_TIMEOUT_EN
                tcnt_n = tcnt + CNT_W'(1);
                fin    = pready || (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
                fin    = pready;
`endif
                // A missing pready at completion can only mean a timeout abort.
                if (fin) begin
                    state_n     = IDLE;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    grant_n     = '0;
                    rr_ptr_n    = idx;
                    req_done_n  = grant;
                    rsp_rdata_n = (pready && !pwrite) ? prdata : '0;
                    rsp_err_n   = pslverr || !pready;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(N_REQ - 1);
            idx       <= '0;
            grant     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            pwakeup   <= 1'b0;
            req_done  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            idx       <= idx_n;
            grant     <= grant_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            pstrb     <= pstrb_n;
            pprot     <= pprot_n;
            pwakeup   <= pwakeup_n;
            req_done  <= req_done_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
`ifdef APB_TIMEOUT_EN
            tcnt      <= tcnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb_apb_rr_master_arbiter: directed bench for the round-robin APB master with a small memory slave.
module tb_apb_rr_master_arbiter;
    localparam int N = 2, AW = 30, DW = 32, SW = 4;
`ifdef APB_TIMEOUT_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 5;
`endif

    logic            pclk = 1'b0, prst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_strb = '0;
    logic [N*3-1:0]  req_prot = '0;
    logic [N-1:0]    req_done, grant;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic            rsp_err, pwakeup, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]   paddr;
    logic [SW-1:0]   pstrb;
    logic [2:0]      pprot;
    logic            ready_ctl = 1'b1, err_ctl = 1'b0;
    logic [DW-1:0]   mem [0:15];
    int              n_chk = 0, n_bad = 0;

    always #5 pclk = ~pclk;

    apb_rr_master_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .prst_n(prst_n), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .grant(grant), .pwakeup(pwakeup), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    assign pready  = ready_ctl;
    assign pslverr = err_ctl;
    assign prdata  = mem[paddr[5:2]];
    always @(posedge pclk) if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = 4'hF;
        req_prot[i*3 +: 3]    = 3'b010;
        req_valid[i]          = 1'b1;
    endtask

    initial begin
        tick;
        chk("rst_outs", {psel, penable, grant, pwakeup, req_done, rsp_err}, '0);
        prst_n = 1'b1;
        tick;
        // write from req0
        set_req(0, 1'b1, 30'h10, 32'hDEADBEEF);
        tick;
        chk("t1_setup", {psel, penable, grant, pwakeup, pwrite}, {1'b1, 1'b0, 2'b01, 1'b1, 1'b1});
        chk("t1_payload", {paddr, pstrb, pprot}, {30'h10, 4'hF, 3'b010});
        chk("t1_pwdata", pwdata, 32'hDEADBEEF);
        tick;
        chk("t1_access", {psel, penable, req_done}, {1'b1, 1'b1, 2'b00});
        tick;
        chk("t1_done", {req_done, rsp_err, psel, penable, grant, pwakeup}, {2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1});
        req_valid[0] = 1'b0;
        tick;
        chk("t1_after", {req_done, pwakeup}, '0);
        // read back from req1
        set_req(1, 1'b0, 30'h10, 32'h0);
        tick;
        chk("t2_setup", {grant, pwrite, pstrb, psel}, {2'b10, 1'b0, 4'h0, 1'b1});
        tick;
        tick;
        chk("t2_done", {req_done, rsp_err}, {2'b10, 1'b0});
        chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);
        req_valid[1] = 1'b0;
        tick;
        chk("t2_rdata_clr", {req_done, rsp_rdata}, '0);
        // both requesting continuously from reset
        prst_n = 1'b0;
        set_req(0, 1'b1, 30'h20, 32'h11111111);
        set_req(1, 1'b1, 30'h24, 32'h22222222);
        tick;
        chk("t3_in_rst", {psel, grant, req_done}, '0);
        prst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("t3_grant%0d", i), {grant, req_done}, {(i % 2) ? 2'b10 : 2'b01, 2'b00});
            chk($sformatf("t3_wdata%0d", i), pwdata, (i % 2) ? 32'h22222222 : 32'h11111111);
            tick;
            tick;
            chk($sformatf("t3_done%0d", i), {req_done, psel}, {(i % 2) ? 2'b10 : 2'b01, 1'b0});
        end
        req_valid = '0;
        tick;
        chk("t3_idle", {pwakeup, psel, req_done}, '0);
        // slow slave with error
        ready_ctl = 1'b0;
        set_req(0, 1'b0, 30'h10, 32'h0);
        tick;
        tick;
        for (int i = 0; i <= HOLD; i++) begin
            chk($sformatf("t4_hold%0d", i), {psel, penable, pwakeup, req_done, grant, paddr}, {1'b1, 1'b1, 1'b1, 2'b00, 2'b01, 30'h10});
            if (i == HOLD) begin
                ready_ctl = 1'b1;
                err_ctl   = 1'b1;
            end
            tick;
        end
        chk("t4_done", {req_done, rsp_err}, {2'b01, 1'b1});
        req_valid = '0;
        err_ctl   = 1'b0;
        tick;
        chk("t4_err_clr", {req_done, rsp_err}, '0);
        // reset during ACCESS
        ready_ctl = 1'b0;
        set_req(1, 1'b1, 30'h30, 32'h55);
        tick;
        chk("t5_grant", grant, 2'b10);
        tick;
        tick;
        #2 prst_n = 1'b0;
        #1 chk("t5_async", {psel, penable, grant, pwakeup, req_done, rsp_err}, '0);
        tick;
        chk("t5_no_done", {req_done, psel}, '0);
        set_req(0, 1'b0, 30'h10, 32'h0);
        ready_ctl = 1'b1;
        prst_n    = 1'b1;
        tick;
        chk("t5_rr_reset", grant, 2'b01);
        tick;
        tick;
        chk("t5_done0", req_done, 2'b01);
        req_valid[0] = 1'b0;
        tick;
        chk("t5_next1", grant, 2'b10);
        tick;
        tick;
        chk("t5_done1", req_done, 2'b10);
        req_valid = '0;
        tick;
`ifdef APB_TIMEOUT_EN
        ready_ctl = 1'b0;
        set_req(0, 1'b0, 30'h10, 32'h0);
        set_req(1, 1'b0, 30'h10, 32'h0);
        tick;
        chk("t6_grant", grant, 2'b01);
        tick;
        for (int i = 1; i <= 4; i++) begin
            tick;
            if (i < 4) chk($sformatf("t6_wait%0d", i), {req_done, psel}, {2'b00, 1'b1});
        end
        chk("t6_abort", {req_done, rsp_err, psel, penable}, {2'b01, 1'b1, 1'b0, 1'b0});
        chk("t6_rdata", rsp_rdata, 32'h0);
        req_valid[0] = 1'b0;
        tick;
        chk("t6_next", grant, 2'b10);
        ready_ctl = 1'b1;
        tick;
        tick;
        chk("t6_done1", req_done, 2'b10);
        req_valid = '0;
        tick;
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
